sha1_wb_arbiter: RTL and testbench

SHA1_WB_ARBITER -- requirements
Module: sha1_wb_arbiter

---
 rtl/sha1_wb_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_sha1_wb_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_wb_arbiter.sv
`default_nettype none
// sha1_wb_arbiter: two-master Wishbone arbiter in front of a SHA1 engine, with
// session locking, lock timeout and an engine-ack watchdog.
module sha1_wb_arbiter #(
  parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
  parameter logic [15:0] LOCK_TIMEOUT = 16'd4096
) (
  input  logic        wb_clk_i,
  input  logic        reset,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic        locked_o,
  output logic        owner_o,
  output logic        timeout_o
);

  localparam logic [31:0] LOCAL_DATA = 32'hfffffff0;
  localparam logic [31:0] WDOG_DATA  = 32'hdeaddead;
  localparam logic [3:0]  WDOG_LAST  = 4'd15;
  localparam logic [2:0]  W_CTRL     = 3'd2;
  localparam logic [2:0]  W_BLOCK    = 3'd3;
  localparam logic [2:0]  W_DIGEST   = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    LOCAL = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t      state;
  logic        grant;
  logic        prio;
  logic        locked;
  logic        owner;
  logic        timeout;
  logic [2:0]  rd_cnt;
  logic [15:0] idle_cnt;
  logic [3:0]  wd_cnt;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat;

  function automatic logic in_window(input logic [31:0] a);
    in_window = (a >= BASE_ADDRESS) && ((a - BASE_ADDRESS) <= 32'h14);
  endfunction

  function automatic logic [2:0] word_of(input logic [31:0] a);
    word_of = 3'((a - BASE_ADDRESS) >> 2);
  endfunction

  logic        req0;
  logic        req1;
  logic        want;
  logic        pick;
  logic [2:0]  pick_word;
  logic        denied;

  assign req0 = m0_stb_i & m0_cyc_i & in_window(m0_adr_i);
  assign req1 = m1_stb_i & m1_cyc_i & in_window(m1_adr_i);
  assign want = req0 | req1;
  // On contention the master not served last wins.
  assign pick      = (req0 & req1) ? prio : req1;
  assign pick_word = pick ? word_of(m1_adr_i) : word_of(m0_adr_i);
  assign denied    = locked & (pick != owner) &
                     ((pick_word == W_CTRL) | (pick_word == W_BLOCK) | (pick_word == W_DIGEST));

  logic        wd_fire;
  logic        fwd_reply;
  logic        reply;
  logic [31:0] reply_data;

  assign wd_fire   = (state == FWD) & ~s_ack_i & (wd_cnt == WDOG_LAST);
  assign fwd_reply = (state == FWD) & (s_ack_i | wd_fire);
  assign reply     = fwd_reply | (state == LOCAL);

  always_comb begin
    reply_data = 32'h0;
    if (state == FWD)
      reply_data = wd_fire ? WDOG_DATA : s_dat_i;
    else if (state == LOCAL)
      reply_data = LOCAL_DATA;
  end

  // A master that dropped its strobe mid-transfer simply never sees the ack.
  assign m0_ack_o = reply & ~grant & m0_stb_i & m0_cyc_i;
  assign m1_ack_o = reply &  grant & m1_stb_i & m1_cyc_i;
  assign m0_dat_o = ~grant ? reply_data : 32'h0;
  assign m1_dat_o =  grant ? reply_data : 32'h0;

  logic [2:0]  s_word;
  logic        engine_ack;
  logic        owner_ack;
  logic        acquire;
  logic        rel_write;
  logic        digest_read;
  logic        idle_expire;
  logic        release_now;

  assign s_word      = word_of(adr);
  assign engine_ack  = (state == FWD) & s_ack_i;
  assign owner_ack   = locked & (grant == owner) & fwd_reply;
  assign acquire     = engine_ack & ~locked & we &
                       ((s_word == W_BLOCK) | ((s_word == W_CTRL) & dat[0]));
  assign rel_write   = engine_ack & locked & (grant == owner) & we &
                       (s_word == W_CTRL) & ~dat[0];
  assign digest_read = engine_ack & locked & (grant == owner) & ~we &
                       (s_word == W_DIGEST) & (s_dat_i != LOCAL_DATA);
  assign idle_expire = locked & ~owner_ack & (idle_cnt == LOCK_TIMEOUT - 16'd1);
  assign release_now = rel_write | (digest_read & (rd_cnt == 3'd4)) | idle_expire;

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= 1'b0;
      prio     <= 1'b0;
      locked   <= 1'b0;
      owner    <= 1'b0;
      timeout  <= 1'b0;
      rd_cnt   <= 3'd0;
      idle_cnt <= 16'd0;
      wd_cnt   <= 4'd0;
      stb      <= 1'b0;
      cyc      <= 1'b0;
      we       <= 1'b0;
      sel      <= 4'h0;
      adr      <= 32'h0;
      dat      <= 32'h0;
    end else begin
      timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (want) begin
            grant <= pick;
            prio  <= ~pick;
            if (denied) begin
              state <= LOCAL;
            end else begin
              state  <= FWD;
              wd_cnt <= 4'd0;
              stb    <= 1'b1;
              cyc    <= 1'b1;
              we     <= pick ? m1_we_i  : m0_we_i;
              sel    <= pick ? m1_sel_i : m0_sel_i;
              adr    <= pick ? m1_adr_i : m0_adr_i;
              dat    <= pick ? m1_dat_i : m0_dat_i;
            end
          end
        end
        FWD: begin
          if (s_ack_i | wd_fire) begin
            state <= GAP;
            stb   <= 1'b0;
            cyc   <= 1'b0;
            we    <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 4'd1;
          end
        end
        LOCAL:   state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase

      // Release always wins; a new owner can only take the lock on a later transfer.
      if (release_now) begin
        locked   <= 1'b0;
        rd_cnt   <= 3'd0;
        idle_cnt <= 16'd0;
        timeout  <= idle_expire;
      end else if (acquire) begin
        locked   <= 1'b1;
        owner    <= grant;
        rd_cnt   <= 3'd0;
        idle_cnt <= 16'd0;
      end else if (locked) begin
        if (digest_read)
          rd_cnt <= rd_cnt + 3'd1;
        idle_cnt <= owner_ack ? 16'd0 : idle_cnt + 16'd1;
      end
    end
  end

  assign s_stb_o   = stb;
  assign s_cyc_o   = cyc;
  assign s_we_o    = we;
  assign s_sel_o   = sel;
  assign s_adr_o   = adr;
  assign s_dat_o   = dat;
  assign locked_o  = locked;
  assign owner_o   = owner;
  assign timeout_o = timeout;

endmodule
`default_nettype wire

// File: tb/tb_sha1_wb_arbiter.sv
`default_nettype none
// tb_sha1_wb_arbiter: directed and random checks of the SHA1 Wishbone arbiter
// against a transaction-level lock model and a simple engine stub.
module tb_sha1_wb_arbiter;

  localparam logic [31:0] BASE = 32'h30000024;
  localparam logic [15:0] TMO  = 16'd4096;
  localparam logic [31:0] SIG  = 32'h53484131;
  localparam logic [31:0] DENY = 32'hfffffff0;
  localparam logic [31:0] WDOG = 32'hdeaddead;
  localparam logic [31:0] DIGEST [5] = '{32'hc3d2e1f0, 32'h10325476, 32'h98badcfe,
                                         32'hefcdab89, 32'h67452301};

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_stb, m0_cyc, m0_we, m1_stb, m1_cyc, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_stb, s_cyc, s_we, s_ack;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat, s_rdat;
  logic        locked, owner, timeout;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sha1_wb_arbiter #(.BASE_ADDRESS(BASE), .LOCK_TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .reset(reset),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack), .m0_dat_o(m0_rdat),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack), .m1_dat_o(m1_rdat),
    .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_dat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .locked_o(locked), .owner_o(owner), .timeout_o(timeout)
  );

  // Engine stub: acks one cycle after seeing a strobe, digest reads rotate.
  logic        st_en;
  logic        ack_q;
  logic [31:0] st_mem [6];
  int          st_ptr;
  logic [2:0]  st_word;

  assign st_word = 3'((s_adr - BASE) >> 2);
  assign s_ack   = ack_q & s_stb;

  always_comb begin
    s_rdat = 32'h0;
    if (st_word == 3'd1)      s_rdat = SIG;
    else if (st_word == 3'd4) s_rdat = DIGEST[st_ptr];
    else if (st_word <= 3'd5) s_rdat = st_mem[st_word];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q  <= 1'b0;
      st_ptr <= 0;
      for (int k = 0; k < 6; k++) st_mem[k] <= 32'h0;
    end else begin
      ack_q <= st_en & s_stb & s_cyc & ~ack_q;
      if (ack_q & s_stb) begin
        if (s_we) st_mem[st_word] <= s_dat;
        else if (st_word == 3'd4) st_ptr <= (st_ptr + 1) % 5;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit m, input bit act, input bit wr, input logic [31:0] off,
                       input logic [31:0] d);
    if (m) begin
      m1_stb = act; m1_cyc = act; m1_we = wr; m1_sel = act ? 4'hf : 4'h0;
      m1_adr = BASE + off; m1_dat = d;
    end else begin
      m0_stb = act; m0_cyc = act; m0_we = wr; m0_sel = act ? 4'hf : 4'h0;
      m0_adr = BASE + off; m0_dat = d;
    end
  endtask

  // One transfer; lat = cycles from request to ack (0 if it never came).
  task automatic xfer(input bit m, input bit wr, input logic [31:0] off, input logic [31:0] d,
                      output logic [31:0] rdata, output int lat, output bit seen);
    bit got;
    got = 1'b0; lat = 0; seen = 1'b0; rdata = 32'h0;
    @(negedge clk);
    drive(m, 1'b1, wr, off, d);
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (s_stb) seen = 1'b1;
      if (m ? m1_ack : m0_ack) begin
        got = 1'b1; lat = i; rdata = m ? m1_rdat : m0_rdat;
      end
    end
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  // Both masters issue the same read together; records each ack cycle.
  task automatic dual(input logic [31:0] off, output int lat0, output int lat1,
                      output logic [31:0] d0, output logic [31:0] d1, output logic stb3);
    lat0 = 0; lat1 = 0; d0 = 32'h0; d1 = 32'h0; stb3 = 1'bx;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, off, 32'h0);
    drive(1'b1, 1'b1, 1'b0, off, 32'h0);
    for (int i = 1; i <= 40 && (lat0 == 0 || lat1 == 0); i++) begin
      @(negedge clk);
      if (i == 3) stb3 = s_stb;
      if (lat0 == 0 && m0_ack) begin lat0 = i; d0 = m0_rdat; drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); end
      if (lat1 == 0 && m1_ack) begin lat1 = i; d1 = m1_rdat; drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0); end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] rd, d0, d1, off, d, exp_d;
  logic        stb3;
  int          lat, lat0, lat1, first_to, pulses;
  bit          seen, m, wr, prot;
  bit          mdl_locked, mdl_owner;
  int          mdl_rc, mdl_ptr;
  logic [31:0] mdl_mem [6];

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    st_en = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s_stb", s_stb, 0);   chk("rst_s_cyc", s_cyc, 0);   chk("rst_s_we", s_we, 0);
    chk("rst_s_sel", s_sel, 0);   chk("rst_s_adr", s_adr, 0);   chk("rst_s_dat", s_dat, 0);
    chk("rst_m0_ack", m0_ack, 0); chk("rst_m0_dat", m0_rdat, 0);
    chk("rst_m1_ack", m1_ack, 0); chk("rst_m1_dat", m1_rdat, 0);
    chk("rst_locked", locked, 0); chk("rst_owner", owner, 0);   chk("rst_timeout", timeout, 0);
    reset = 1'b0;

    // First contention after reset goes to m0; m1 follows after the gap.
    dual(32'h4, lat0, lat1, d0, d1, stb3);
    chk("dual_m0_lat", lat0, 2); chk("dual_m0_dat", d0, SIG);
    chk("dual_gap_stb", stb3, 0);
    chk("dual_m1_lat", lat1, 6); chk("dual_m1_dat", d1, SIG);

    // After m0 is served alone, contention favours m1.
    xfer(1'b0, 1'b0, 32'h0, 32'h0, rd, lat, seen);
    chk("m0_single_lat", lat, 2);
    dual(32'h4, lat0, lat1, d0, d1, stb3);
    chk("dual2_m1_lat", lat1, 2); chk("dual2_m0_lat", lat0, 6);

    // m0 streams a block and takes the lock.
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, 1'b1, 32'hC, 32'h1000 + i, rd, lat, seen);
      if (i == 0) chk("block_lat", lat, 2);
    end
    chk("lock_m0_locked", locked, 1); chk("lock_m0_owner", owner, 0);

    xfer(1'b1, 1'b0, 32'h10, 32'h0, rd, lat, seen);
    chk("deny_lat", lat, 1); chk("deny_dat", rd, DENY); chk("deny_no_stb", seen, 0);
    xfer(1'b1, 1'b0, 32'h4, 32'h0, rd, lat, seen);
    chk("nonowner_sig_lat", lat, 2); chk("nonowner_sig_dat", rd, SIG);

    for (int i = 0; i < 5; i++) begin
      xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, lat, seen);
      chk("digest_dat", rd, DIGEST[i]);
      chk("digest_locked", locked, (i < 4) ? 1 : 0);
    end

    xfer(1'b1, 1'b1, 32'h8, 32'h1, rd, lat, seen);
    chk("m1_ctrl_lat", lat, 2); chk("m1_ctrl_fwd", seen, 1);
    chk("lock_m1_locked", locked, 1); chk("lock_m1_owner", owner, 1);

    // Lock timeout: released TMO cycles after the acquiring edge.
    first_to = 0; pulses = 0;
    for (int i = 1; i <= int'(TMO) + 10; i++) begin
      @(negedge clk);
      if (i == int'(TMO) - 1) chk("tmo_still_locked", locked, 1);
      if (timeout) begin pulses++; if (first_to == 0) first_to = i; end
    end
    chk("tmo_cycle", first_to, int'(TMO)); chk("tmo_pulses", pulses, 1);
    chk("tmo_unlocked", locked, 0);

    // Random single-master traffic against the session model.
    do_reset();
    mdl_locked = 1'b0; mdl_owner = 1'b0; mdl_rc = 0; mdl_ptr = 0;
    for (int k = 0; k < 6; k++) mdl_mem[k] = 32'h0;
    for (int t = 0; t < 80; t++) begin
      m   = 1'($urandom % 2);
      wr  = 1'($urandom % 2);
      off = 32'($urandom_range(0, 5)) * 32'd4;
      d   = $urandom;
      prot = mdl_locked && (m != mdl_owner) && (off == 32'h8 || off == 32'hC || off == 32'h10);
      xfer(m, wr, off, d, rd, lat, seen);
      if (prot) begin
        chk("rnd_deny_lat", lat, 1); chk("rnd_deny_dat", rd, DENY); chk("rnd_deny_stb", seen, 0);
      end else begin
        chk("rnd_fwd_lat", lat, 2); chk("rnd_fwd_stb", seen, 1);
        if (!wr) begin
          exp_d = (off == 32'h4) ? SIG : (off == 32'h10) ? DIGEST[mdl_ptr] : mdl_mem[off / 4];
          chk("rnd_rd_dat", rd, exp_d);
          if (off == 32'h10) mdl_ptr = (mdl_ptr + 1) % 5;
        end else begin
          mdl_mem[off / 4] = d;
        end
        if (!mdl_locked) begin
          if (wr && (off == 32'hC || (off == 32'h8 && d[0]))) begin
            mdl_locked = 1'b1; mdl_owner = m; mdl_rc = 0;
          end
        end else if (m == mdl_owner) begin
          if (wr && off == 32'h8 && !d[0]) begin
            mdl_locked = 1'b0; mdl_rc = 0;
          end else if (!wr && off == 32'h10) begin
            mdl_rc++;
            if (mdl_rc == 5) begin mdl_locked = 1'b0; mdl_rc = 0; end
          end
        end
      end
      chk("rnd_locked", locked, mdl_locked);
      if (mdl_locked) chk("rnd_owner", owner, mdl_owner);
    end

    // Watchdog, then reset in the middle of a hung transfer.
    do_reset();
    xfer(1'b1, 1'b1, 32'hC, 32'h0, rd, lat, seen);
    chk("wd_pre_locked", locked, 1);
    st_en = 1'b0;
    xfer(1'b0, 1'b0, 32'h0, 32'h0, rd, lat, seen);
    chk("wd_lat", lat, 16); chk("wd_dat", rd, WDOG);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    repeat (4) @(negedge clk);
    chk("hang_stb", s_stb, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_s_stb", s_stb, 0);   chk("mid_rst_s_cyc", s_cyc, 0); chk("mid_rst_s_we", s_we, 0);
    chk("mid_rst_s_sel", s_sel, 0);   chk("mid_rst_s_adr", s_adr, 0); chk("mid_rst_s_dat", s_dat, 0);
    chk("mid_rst_m1_ack", m1_ack, 0); chk("mid_rst_m1_dat", m1_rdat, 0);
    chk("mid_rst_locked", locked, 0); chk("mid_rst_owner", owner, 0);
    chk("mid_rst_timeout", timeout, 0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    st_en = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
